pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multicycle fetch/update controller that sequences the program-counter register of the RV64I SiMPLE core. It issues instruction-memory fetch requests at the current PC, waits for execution to finish, selects the next PC by priority (trap, mret, redirect, sequential), and drives the register's write enable. It also counts retired instructions. Sits between the control unit, the CSR/trap logic, instruction memory and the program-counter register.

## Interface
- RESET_PC, 32'h0000_0000, value loaded into the PC on the first cycle after reset
- TRAP_VECTOR, 32'h0000_0100, trap handler entry; must be 4-byte aligned
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- pc  in  32  current PC from the program-counter register
- pc_en  out  1  write enable to the program-counter register
- next_pc  out  32  value to load when pc_en=1
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  32  fetch address, equal to pc while imem_req=1
- imem_ack  in  1  fetch data valid; may arrive in the same cycle as imem_req
- fetch_valid  out  1  one-cycle pulse: instruction available to the core
- instr_done  in  1  execution complete; redirect/trap/mret qualifiers valid this cycle
- stall  in  1  hold the PC update while high, even if instr_done=1
- redirect  in  1  branch taken / jump
- redirect_target  in  32  branch/jump target
- trap  in  1  exception or interrupt taken
- mret  in  1  return from trap
- mepc  in  32  return address for mret
- instret  out  64  retired-instruction counter
- misaligned_exc  out  1  misaligned-target pulse (only with PC_MISALIGN_TRAP_EN)

## Operation
- States: INIT, FETCH, EXECUTE.
- INIT: pc_en=1, next_pc=RESET_PC. Transition to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, transition to EXECUTE. stall is ignored in FETCH.
- EXECUTE: wait for instr_done & !stall. When it arrives, assert pc_en=1 for that cycle and transition to FETCH. With instr_done=1 and stall=1, remain in EXECUTE with pc_en=0.
- next_pc priority when several qualifiers are high: trap → TRAP_VECTOR; mret → mepc; redirect → redirect_target; otherwise pc+4. Addition wraps modulo 2^32.
- instret increments by 1 on every EXECUTE update with trap=0. It wraps from 2^64-1 to 0.
- Reset outputs: pc_en=0, next_pc=RESET_PC, imem_req=0, imem_addr=0, fetch_valid=0, instret=0, misaligned_exc=0.
- The state register resets to INIT.
- Asserting rst mid-fetch or mid-execute aborts the operation immediately, with no pending pc_en.

## Timing
- fetch_valid is registered: it pulses the cycle after imem_ack is sampled, coinciding with the first EXECUTE cycle.
- pc_en and next_pc are combinational from the state and inputs within the EXECUTE cycle in which the update condition holds. The PC register captures on the next edge.
- Fastest instruction is 2 cycles: FETCH with same-cycle ack, then EXECUTE with instr_done=1.
- From rst deassertion: INIT in cycle 0, first imem_req in cycle 1.
- instret updates on the same edge at which the PC register captures.

## Configuration
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect or mret target with bits[1:0]≠0 is replaced by TRAP_VECTOR.
  - misaligned_exc pulses for one cycle, coinciding with pc_en.
  - instret is not incremented for that instruction.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 for every source.
  - misaligned_exc is tied to 0.

## Structure
- Package pc_sequencer_pkg holds the state encoding (INIT, FETCH, EXECUTE), the next-PC source-select encoding (SEL_TRAP, SEL_MRET, SEL_REDIRECT, SEL_SEQ), and the PC_STEP=4 constant.
- Sub-module next_pc_select is the combinational priority mux plus alignment handling. Its inputs are the qualifiers and addresses; its outputs are next_pc, the source select and the misaligned flag.

## Test plan
- Reset, then a run with ack in the same cycle as the request and instr_done on the first EXECUTE cycle, no redirect:
  - pc_en in cycle 0 with next_pc=0x0.
  - pc takes the values 0x0, 0x4, 0x8, with one update every 2 cycles.
  - instret=3 after three instructions.
- At pc=0x10, redirect=1, trap=1, mret=1, target=0x200, mepc=0x300, all asserted together:
  - next_pc=0x100.
  - instret is unchanged.
- At pc=0x20, instr_done=1 with stall=1 held for 3 cycles:
  - pc_en stays 0 during the stall.
  - pc_en=1 in the cycle stall drops, with next_pc=0x24.
- imem_ack delayed 4 cycles:
  - imem_req and imem_addr stay stable throughout.
  - fetch_valid pulses exactly once.
- redirect_target=0x202:
  - With PC_MISALIGN_TRAP_EN: next_pc=0x100 and misaligned_exc=1.
  - Without: next_pc=0x200.
- rst asserted asynchronously during EXECUTE: outputs reach their reset values before the next edge, and the sequence restarts at INIT.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: FSM states, next-PC source selects and the sequential step.
package pc_sequencer_pkg;

    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] EXECUTE = 2'd2;

    localparam logic [1:0] SEL_TRAP     = 2'd0;
    localparam logic [1:0] SEL_MRET     = 2'd1;
    localparam logic [1:0] SEL_REDIRECT = 2'd2;
    localparam logic [1:0] SEL_SEQ      = 2'd3;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_select.sv
// Priority mux for the next PC (trap > mret > redirect > pc+4) with alignment handling.
// PC_MISALIGN_TRAP_EN: misaligned redirect/mret targets divert to the trap vector; otherwise bits[1:0] are cleared.
module next_pc_select
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [31:0] pc,
    input  logic        trap,
    input  logic        mret,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] mepc,
    output logic [31:0] next_pc,
    output logic [1:0]  sel,
    output logic        misaligned
);

    logic [31:0] raw_pc;

    always_comb begin
        raw_pc = pc + PC_STEP;
        sel    = SEL_SEQ;
        if (trap) begin
            raw_pc = TRAP_VECTOR;
            sel    = SEL_TRAP;
        end else if (mret) begin
            raw_pc = mepc;
            sel    = SEL_MRET;
        end else if (redirect) begin
            raw_pc = redirect_target;
            sel    = SEL_REDIRECT;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Only externally supplied targets can be misaligned; trap vector and pc+4 are aligned by construction.
    assign misaligned = ((sel == SEL_MRET) || (sel == SEL_REDIRECT)) && is_misaligned(raw_pc);
    assign next_pc    = misaligned ? TRAP_VECTOR : raw_pc;
`else
    assign misaligned = 1'b0;
    assign next_pc    = {raw_pc[31:2], 2'b00};
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle INIT/FETCH/EXECUTE controller for the PC register, plus the retired-instruction counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (see next_pc_select).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_en,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    input  logic        instr_done,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    input  logic        mret,
    input  logic [31:0] mepc,
    output logic [63:0] instret,
    output logic        misaligned_exc,
    output logic [1:0]  state_dbg
);

    logic [1:0]  state_q, state_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] sel_pc;
    logic [1:0]  sel_src;
    logic        sel_mis;

    next_pc_select #(.TRAP_VECTOR(TRAP_VECTOR)) u_sel (
        .pc              (pc),
        .trap            (trap),
        .mret            (mret),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mepc            (mepc),
        .next_pc         (sel_pc),
        .sel             (sel_src),
        .misaligned      (sel_mis)
    );

    always_comb begin
        state_d        = state_q;
        fetch_valid_d  = 1'b0;
        instret_d      = instret_q;
        pc_en          = 1'b0;
        next_pc        = RESET_PC;
        imem_req       = 1'b0;
        imem_addr      = 32'h0;
        misaligned_exc = 1'b0;
        case (state_q)
            INIT: begin
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_ack) begin
                    fetch_valid_d = 1'b1;
                    state_d       = EXECUTE;
                end
            end
            EXECUTE: begin
                next_pc = sel_pc;
                if (instr_done && !stall) begin
                    pc_en          = 1'b1;
                    misaligned_exc = sel_mis;
                    state_d        = FETCH;
                    if ((sel_src != SEL_TRAP) && !sel_mis)
                        instret_d = instret_q + 64'd1;
                end
            end
            default: state_d = INIT;
        endcase
        // Reset is asynchronous: outputs must look idle while rst is high, not after the next edge.
        if (rst) begin
            pc_en          = 1'b0;
            next_pc        = RESET_PC;
            imem_req       = 1'b0;
            imem_addr      = 32'h0;
            misaligned_exc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= INIT;
            fetch_valid_q <= 1'b0;
            instret_q     <= 64'd0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            instret_q     <= instret_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign instret     = instret_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the bench models the PC register and an expected-update queue.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_en;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        fetch_valid;
    logic        instr_done = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        trap = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] mepc = 32'h0;
    logic [63:0] instret;
    logic        misaligned_exc;
    logic [1:0]  state_dbg;

    int          tests = 0;
    int          fails = 0;
    int          fv_count = 0;
    logic [63:0] exp_instret = 64'd0;
    logic [32:0] exp_q[$];
    logic [31:0] pc_reg = 32'h0000_1230;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_NEXT = 32'h0000_0100;
    localparam logic        MIS_EXC  = 1'b1;
`else
    localparam logic [31:0] MIS_NEXT = 32'h0000_0200;
    localparam logic        MIS_EXC  = 1'b0;
`endif

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid), .instr_done(instr_done), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target), .trap(trap),
        .mret(mret), .mepc(mepc), .instret(instret),
        .misaligned_exc(misaligned_exc), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    assign pc = pc_reg;
    always @(posedge clk) if (pc_en) pc_reg <= next_pc;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every PC update must match the head of the expected queue
    logic [32:0] exp_e;
    always @(negedge clk) begin
        if (fetch_valid) fv_count++;
        if (misaligned_exc && !pc_en) check("mis_without_pc_en", 64'(misaligned_exc), 64'(pc_en));
        if (pc_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pc_en", 64'(pc_en), 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("next_pc", 64'(next_pc), 64'(exp_e[31:0]));
                check("misaligned_exc", 64'(misaligned_exc), 64'(exp_e[32]));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_en"}, 64'(pc_en), 64'd0);
        check({tag, "_next_pc"}, 64'(next_pc), 64'd0);
        check({tag, "_imem_req"}, 64'(imem_req), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
        check({tag, "_misaligned"}, 64'(misaligned_exc), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // driver: called at posedge+1 while in FETCH; returns at posedge+1 in the next FETCH
    task automatic run_instr(input int ack_wait, input int stall_n,
                             input logic tr, input logic mr, input logic rd,
                             input logic [31:0] tgt, input logic [31:0] mp,
                             input logic [31:0] exp_next, input logic exp_mis);
        int fv0;
        fv0 = fv_count;
        for (int i = 0; i < ack_wait; i++) begin
            @(negedge clk);
            check("imem_req_wait", 64'(imem_req), 64'd1);
            check("imem_addr_wait", 64'(imem_addr), 64'(pc_reg));
            check("fetch_valid_wait", 64'(fetch_valid), 64'd0);
            @(posedge clk); #1;
        end
        imem_ack = 1'b1;
        @(negedge clk);
        check("imem_req", 64'(imem_req), 64'd1);
        check("imem_addr", 64'(imem_addr), 64'(pc_reg));
        @(posedge clk); #1;
        imem_ack = 1'b0;
        trap = tr; mret = mr; redirect = rd; redirect_target = tgt; mepc = mp;
        instr_done = 1'b1;
        stall = (stall_n > 0);
        if (!tr && !exp_mis) exp_instret = exp_instret + 64'd1;
        if (stall_n == 0) exp_q.push_back({exp_mis, exp_next});
        @(negedge clk);
        check("fetch_valid_pulse", 64'(fetch_valid), 64'd1);
        if (stall_n > 0) check("stall_pc_en", 64'(pc_en), 64'd0);
        for (int s = 1; s < stall_n; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_pc_en", 64'(pc_en), 64'd0);
        end
        if (stall_n > 0) begin
            @(posedge clk); #1;
            stall = 1'b0;
            exp_q.push_back({exp_mis, exp_next});
            @(negedge clk);
        end
        @(posedge clk); #1;
        instr_done = 1'b0; trap = 1'b0; mret = 1'b0; redirect = 1'b0;
        check("pc_reg", 64'(pc_reg), 64'(exp_next));
        check("instret", instret, exp_instret);
        check("fetch_valid_count", 64'(fv_count - fv0), 64'd1);
    endtask

    initial begin
        // reset state
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        check("init_state", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        check("pc_after_init", 64'(pc_reg), 64'h0);

        // back-to-back 2-cycle instructions
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 1'b0);
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h8, 1'b0);
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'hC, 1'b0);
        check("instret_three", instret, 64'd3);
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h10, 1'b0);

        // all qualifiers together: trap wins, not retired
        run_instr(0, 0, 1, 1, 1, 32'h200, 32'h300, 32'h100, 1'b0);
        check("instret_after_trap", instret, 64'd4);

        // redirect to 0x20, then stall for 3 cycles
        run_instr(0, 0, 0, 0, 1, 32'h20, 32'h0, 32'h20, 1'b0);
        run_instr(0, 3, 0, 0, 0, 32'h0, 32'h0, 32'h24, 1'b0);

        // slow memory
        run_instr(4, 0, 0, 0, 0, 32'h0, 32'h0, 32'h28, 1'b0);

        // misaligned redirect target
        run_instr(0, 0, 0, 0, 1, 32'h202, 32'h0, MIS_NEXT, MIS_EXC);

        // mret beats redirect
        run_instr(1, 0, 0, 1, 1, 32'h400, 32'h300, 32'h300, 1'b0);

        // sequential wrap modulo 2^32
        run_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);

        // asynchronous reset during EXECUTE with an update pending
        imem_ack = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        instr_done = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("mid_exec_rst");
        instr_done = 1'b0;
        exp_instret = 64'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        check("restart_state", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        run_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 1'b0);

        repeat (2) @(posedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
